// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when a borrow is needed.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Handshake: start is sampled only in IDLE; done pulses for one cycle when diff/borrow_out update.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds only the upper WIDTH-1 partial-result bits; the lowest bit of a
  // full-width shift register would be shifted out before it is ever read.
  logic [WIDTH-2:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] shifted;

  fs_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign shifted = {cell_d, d_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          brw_d   = borrow_in;
          cnt_d   = '0;
          d_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        d_d   = shifted[WIDTH-1:1];
        brw_d = cell_bo;
        if (cnt_q == LAST) begin
          diff_d  = shifted;
          bo_d    = cell_bo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign dbg_state  = state_q;

endmodule
